// File: rtl/cpu_phase_ctrl.sv
// Instruction-cycle sequencer: turns the four CPU phase strobes into fetch/decode/
// execute/writeback enables, drives the program counter and the instruction fetch request.
module cpu_phase_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_1,
  input  logic             phase_2,
  input  logic             phase_3,
  input  logic             phase_4,
  input  logic             run,
  input  logic             halt_req,
  input  logic             mem_ack,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             mem_req,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [PC_W-1:0]  pc_n;
  logic [CNT_W-1:0] cnt_n;
  logic             mem_req_n, fetch_en_n, decode_en_n, exec_en_n, wb_en_n;
  logic             busy_n, halted_n;
  logic             ack_done, ack_done_n;
  logic             halt_pend, halt_pend_n;
  logic             stop_pend, stop_pend_n;
  logic             got_ack;

  // Fetch handshake: mem_req is held until an edge samples mem_req && mem_ack;
  // that edge completes the transfer. mem_ack with mem_req low means nothing.
  assign got_ack   = mem_req && mem_ack;
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    cnt_n       = instr_count;
    mem_req_n   = mem_req;
    fetch_en_n  = 1'b0;
    decode_en_n = 1'b0;
    exec_en_n   = 1'b0;
    wb_en_n     = 1'b0;
    busy_n      = busy;
    halted_n    = halted;
    ack_done_n  = ack_done;
    halt_pend_n = halt_pend;
    stop_pend_n = stop_pend;
    case (state)
      S_IDLE: begin
        if (phase_1 && run) begin
          state_n    = S_FETCH;
          mem_req_n  = 1'b1;
          busy_n     = 1'b1;
          ack_done_n = 1'b0;
        end
      end
      S_FETCH: begin
        if (!ack_done && got_ack) begin
          mem_req_n  = 1'b0;
          fetch_en_n = 1'b1;
          ack_done_n = 1'b1;
        end
        // phase_2 only counts once the ack has been seen, so a slow memory
        // stretches the instruction by whole phase periods.
        if ((ack_done || got_ack) && phase_2) begin
          state_n     = S_DECODE;
          decode_en_n = 1'b1;
          ack_done_n  = 1'b0;
        end
      end
      S_DECODE: begin
        if (phase_3) begin
          state_n   = S_EXEC;
          exec_en_n = 1'b1;
        end
      end
      S_EXEC: begin
        if (phase_4) begin
          state_n     = S_WB;
          wb_en_n     = 1'b1;
          pc_n        = branch_taken ? branch_target : pc + PC_W'(1);
          cnt_n       = instr_count + CNT_W'(1);
          halt_pend_n = halt_req;
          stop_pend_n = !run;
        end
      end
      S_WB: begin
        // Exit was chosen at the phase_4 edge; WB then waits for the next phase_1.
        if (halt_pend) begin
          state_n  = S_HALT;
          busy_n   = 1'b0;
          halted_n = 1'b1;
        end else if (stop_pend) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end else if (phase_1) begin
          state_n    = S_FETCH;
          mem_req_n  = 1'b1;
          ack_done_n = 1'b0;
        end
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_count <= '0;
      mem_req     <= 1'b0;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      exec_en     <= 1'b0;
      wb_en       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      ack_done    <= 1'b0;
      halt_pend   <= 1'b0;
      stop_pend   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_count <= cnt_n;
      mem_req     <= mem_req_n;
      fetch_en    <= fetch_en_n;
      decode_en   <= decode_en_n;
      exec_en     <= exec_en_n;
      wb_en       <= wb_en_n;
      busy        <= busy_n;
      halted      <= halted_n;
      ack_done    <= ack_done_n;
      halt_pend   <= halt_pend_n;
      stop_pend   <= stop_pend_n;
    end
  end

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Bench for cpu_phase_ctrl: phase generator, memory-ack driver, directed scenarios
// pushing expected output events, and a monitor that pops and compares them.
module tb_cpu_phase_ctrl;
  localparam int W = 38;

  logic        clk;
  logic        rst_n;
  logic        phase_1, phase_2, phase_3, phase_4;
  logic        run, halt_req, mem_ack, branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  pc;
  logic        mem_req, fetch_en, decode_en, exec_en, wb_en, busy, halted;
  logic [15:0] instr_count;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;
  logic ack_tie = 1'b0;
  logic [W-1:0] exp_q[$];

  cpu_phase_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .phase_1(phase_1), .phase_2(phase_2), .phase_3(phase_3), .phase_4(phase_4),
    .run(run), .halt_req(halt_req), .mem_ack(mem_ack),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .mem_req(mem_req), .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .wb_en(wb_en), .busy(busy), .halted(halted),
    .instr_count(instr_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers: phase strobes and memory ack ----------------
  initial begin
    int k;
    k = 0;
    phase_1 = 1'b0; phase_2 = 1'b0; phase_3 = 1'b0; phase_4 = 1'b0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      phase_1 = ((cyc % 10) == 0);
      phase_2 = ((cyc % 10) == 1);
      phase_3 = ((cyc % 10) == 2);
      phase_4 = ((cyc % 10) == 3);
      if (mem_req) k = k + 1;
      else k = 0;
      mem_ack = ack_tie | (mem_req && (k == ack_delay + 1));
    end
  end

  function automatic logic [W-1:0] ev(input logic [3:0] en, input logic b, input logic h,
                                      input logic [3:0] pos, input logic [3:0] rl,
                                      input logic [7:0] p, input logic [15:0] c);
    return {en, b, h, pos, rl, p, c};
  endfunction

  task automatic push(input logic [3:0] en, input logic b, input logic h, input logic [3:0] pos,
                      input logic [3:0] rl, input logic [7:0] p, input logic [15:0] c);
    exp_q.push_back(ev(en, b, h, pos, rl, p, c));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_pos(input int p);
    do @(negedge clk); while ((cyc % 10) != p);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d events outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         pbusy, phalted;
    int           run_len, last_len;
    logic [W-1:0] got, exp;
    logic [3:0]   rl;
    pbusy = 1'b0; phalted = 1'b0; run_len = 0; last_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pbusy = busy; phalted = halted; run_len = 0;
      end else begin
        if (mem_req) run_len++;
        else if (run_len != 0) begin
          last_len = run_len;
          run_len  = 0;
        end
        if (fetch_en || decode_en || exec_en || wb_en || busy != pbusy || halted != phalted) begin
          rl  = fetch_en ? 4'(last_len) : 4'd0;
          got = ev({fetch_en, decode_en, exec_en, wb_en}, busy, halted, 4'(cyc % 10), rl, pc, instr_count);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got en=%b busy=%b halted=%b pos=%0d pc=%h cnt=%0d required no event",
                     got[37:34], got[33], got[32], got[31:28], got[23:16], got[15:0]);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL event: got en=%b busy=%b halted=%b pos=%0d rl=%0d pc=%h cnt=%0d required en=%b busy=%b halted=%b pos=%0d rl=%0d pc=%h cnt=%0d",
                       got[37:34], got[33], got[32], got[31:28], got[27:24], got[23:16], got[15:0],
                       exp[37:34], exp[33], exp[32], exp[31:28], exp[27:24], exp[23:16], exp[15:0]);
            end
          end
        end
        pbusy = busy; phalted = halted;
      end
    end
  end

  // ---------------- scenarios ----------------
  // One instruction with a delayed ack; fpos/fen/rl give where fetch_en lands.
  task automatic one_instr(input int dly, input logic [3:0] fpos, input logic [3:0] fen,
                           input logic [3:0] rl, input logic [7:0] pc0, input logic [7:0] pc1,
                           input logic [15:0] c0);
    push(4'b0000, 1, 0, 1, 0, pc0, c0);
    push(fen, 1, 0, fpos, rl, pc0, c0);
    if (fen == 4'b1000) push(4'b0100, 1, 0, 2, 0, pc0, c0);
    push(4'b0010, 1, 0, 3, 0, pc0, c0);
    push(4'b0001, 1, 0, 4, 0, pc1, c0 + 16'd1);
    push(4'b0000, 0, 0, 5, 0, pc1, c0 + 16'd1);
    ack_tie = 1'b0;
    ack_delay = dly;
    wait_pos(5); run = 1'b1;
    wait_pos(1); run = 1'b0;
    wait_drain();
  endtask

  // Branch to tgt, then one sequential instruction.
  task automatic branch_pair(input logic [7:0] pc0, input logic [7:0] tgt, input logic [7:0] pc2,
                             input logic [15:0] c0);
    push(4'b0000, 1, 0, 1, 0, pc0, c0);
    push(4'b1100, 1, 0, 2, 1, pc0, c0);
    push(4'b0010, 1, 0, 3, 0, pc0, c0);
    push(4'b0001, 1, 0, 4, 0, tgt, c0 + 16'd1);
    push(4'b1100, 1, 0, 2, 1, tgt, c0 + 16'd1);
    push(4'b0010, 1, 0, 3, 0, tgt, c0 + 16'd1);
    push(4'b0001, 1, 0, 4, 0, pc2, c0 + 16'd2);
    push(4'b0000, 0, 0, 5, 0, pc2, c0 + 16'd2);
    ack_tie = 1'b1;
    wait_pos(5); run = 1'b1; branch_taken = 1'b1; branch_target = tgt;
    wait_pos(4); branch_taken = 1'b0; branch_target = 8'h00;
    wait_pos(1); run = 1'b0;
    wait_drain();
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    #1;
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_cnt", 32'(instr_count), 32'h0);
    chk("reset_enables", 32'({mem_req, fetch_en, decode_en, exec_en, wb_en}), 32'h0);
    chk("reset_busy_halted", 32'({busy, halted}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Three back-to-back zero-wait instructions; run dropped in EXEC of the third.
    push(4'b0000, 1, 0, 1, 0, 8'h00, 16'd0);
    push(4'b1100, 1, 0, 2, 1, 8'h00, 16'd0);
    push(4'b0010, 1, 0, 3, 0, 8'h00, 16'd0);
    push(4'b0001, 1, 0, 4, 0, 8'h01, 16'd1);
    push(4'b1100, 1, 0, 2, 1, 8'h01, 16'd1);
    push(4'b0010, 1, 0, 3, 0, 8'h01, 16'd1);
    push(4'b0001, 1, 0, 4, 0, 8'h02, 16'd2);
    push(4'b1100, 1, 0, 2, 1, 8'h02, 16'd2);
    push(4'b0010, 1, 0, 3, 0, 8'h02, 16'd2);
    push(4'b0001, 1, 0, 4, 0, 8'h03, 16'd3);
    push(4'b0000, 0, 0, 5, 0, 8'h03, 16'd3);
    ack_tie = 1'b1;
    wait_pos(5); run = 1'b1;
    wait_pos(1); wait_pos(1); wait_pos(1);
    wait_pos(3); run = 1'b0;
    wait_drain();

    // Delayed acks: 5 clk (one stall), 9 clk (ack just before next phase_2),
    // 10 clk (ack together with next phase_2).
    one_instr(5,  4'd7, 4'b1000, 4'd6,  8'h03, 8'h04, 16'd3);
    one_instr(9,  4'd1, 4'b1000, 4'd10, 8'h04, 8'h05, 16'd4);
    one_instr(10, 4'd2, 4'b1100, 4'd11, 8'h05, 8'h06, 16'd5);

    branch_pair(8'h06, 8'h40, 8'h41, 16'd6);

    // Reset while mem_req is pending.
    push(4'b0000, 1, 0, 1, 0, 8'h41, 16'd8);
    ack_tie = 1'b0;
    ack_delay = 15;
    wait_pos(5); run = 1'b1;
    wait_pos(3);
    chk("fetch_pending_req", 32'(mem_req), 32'h1);
    rst_n = 1'b0; run = 1'b0;
    #1;
    chk("midreset_req_busy", 32'({mem_req, busy}), 32'h0);
    chk("midreset_pc", 32'(pc), 32'h0);
    chk("midreset_cnt", 32'(instr_count), 32'h0);
    chk("midreset_enables", 32'({fetch_en, decode_en, exec_en, wb_en}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    wait_drain();

    branch_pair(8'h00, 8'hFF, 8'h00, 16'd0);

    // Halt with run held high; memory ack tied high to show it is ignored.
    push(4'b0000, 1, 0, 1, 0, 8'h00, 16'd2);
    push(4'b1100, 1, 0, 2, 1, 8'h00, 16'd2);
    push(4'b0010, 1, 0, 3, 0, 8'h00, 16'd2);
    push(4'b0001, 1, 0, 4, 0, 8'h01, 16'd3);
    push(4'b0000, 0, 1, 5, 0, 8'h01, 16'd3);
    ack_tie = 1'b1;
    wait_pos(5); run = 1'b1;
    wait_pos(3); halt_req = 1'b1;
    wait_pos(4); halt_req = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);
    chk("halt_sticky", 32'({halted, busy, mem_req}), 32'h4);
    chk("halt_pc", 32'(pc), 32'h01);
    chk("halt_cnt", 32'(instr_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("halt_reset", 32'({halted, busy, pc}), 32'h0);
    run = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_phase_ctrl.md
# cpu_phase_ctrl

Instruction-cycle sequencer for the CPU core. It consumes the four one-cycle phase strobes produced by the CPU clock generator (period 10 clk, phase_k one clk after phase_k-1). From them it drives the fetch/decode/execute/writeback enables, the program counter and the instruction-memory request handshake. A memory that does not acknowledge in time stretches the instruction by whole phase periods.

## Interface
- PC_W, 8, program counter width
- CNT_W, 16, retired-instruction counter width

- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- phase_1..phase_4  in  1 each  phase strobes; each high exactly 1 clk per period
- run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
- halt_req  in  1  sampled with phase_4; enter HALT after current instruction
- mem_ack  in  1  instruction memory acknowledge
- branch_taken  in  1  sampled with phase_4
- branch_target  in  PC_W  sampled with phase_4
- pc  out  PC_W  current fetch address
- mem_req  out  1  fetch request
- fetch_en, decode_en, exec_en, wb_en  out  1 each  one-clk stage enables
- busy  out  1  state not IDLE/HALT
- halted  out  1  state HALT
- instr_count  out  CNT_W  retired instructions

## Operation
- All outputs registered. Reset (async, immediate): state IDLE, pc=0, instr_count=0, all other outputs 0.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: phase_1 sampled with run=1 -> FETCH, mem_req=1 next clk. Otherwise stay in IDLE; pc is held.
- FETCH:
  - mem_req held high until mem_ack is sampled high.
  - In the clk after that edge: mem_req=0, fetch_en=1 for exactly 1 clk, internal ack_done=1.
  - phase_2 qualifies if sampled at the same edge as mem_ack or any later edge. Qualifying phase_2 -> DECODE.
  - While ack is pending, phase_2/3/4/1 strobes are ignored. The instruction stalls by whole 10-clk periods until the first qualifying phase_2.
- DECODE: decode_en=1 for the clk after phase_2 is accepted. Next phase_3 -> EXEC, exec_en=1 for 1 clk.
- EXEC: next phase_4 -> WB, wb_en=1 for 1 clk. At that same edge:
  - pc <= branch_taken ? branch_target : pc+1, wrapping mod 2^PC_W (e.g. 0xFF -> 0x00 at PC_W=8).
  - instr_count <= instr_count+1, wrapping mod 2^CNT_W.
- WB exit, decided at the phase_4 edge, highest priority first:
  - halt_req=1 -> HALT.
  - run=0 -> IDLE.
  - else -> FETCH on the next phase_1.
- HALT: sticky. Exits only via rst_n; run is ignored.
- run falling mid-instruction does not abort; the current instruction completes through WB.
- mem_ack while mem_req=0 is ignored.
- Phase strobes outside the expected state are ignored. No error flag.

## Timing
- Let phase_1 be high in clk t.
- mem_req is high from t+1. phase_2 is high in clk t+1.
- Zero-wait memory (mem_ack high in t+1):
  - fetch_en and decode_en both high at t+2.
  - exec_en high at t+3.
  - wb_en high at t+4; pc and instr_count update at t+4.
  - Instruction total: one 10-clk period.
- Ack sampled at any edge from t+2 to t+10 (before phase_2 of the next period, high in t+11): decode_en at t+12, exec_en t+13, wb_en t+14. One period of stall.
- Enables are mutually exclusive except fetch_en and decode_en, which coincide in the zero-wait case.
- busy rises with mem_req and falls the clk after the final wb_en when exiting to IDLE/HALT. halted rises in that same clk.
- Back-to-back instructions with run=1: the next mem_req rises at t+11.

## Test plan
- Reset mid-FETCH with mem_req=1 -> mem_req, busy, pc, instr_count all 0 immediately; IDLE on release, no enables until phase_1 with run=1.
- run=1, mem_ack tied high, 3 periods -> fetch_en and decode_en at t+2, exec_en at t+3, wb_en at t+4 each period; pc 0→1→2→3, instr_count=3, mem_req high exactly 1 clk per period.
- mem_ack delayed to 5 clk after mem_req rises -> mem_req high 6 clk, fetch_en at t+7, decode_en at t+12, wb_en at t+14, pc=1.
- branch_taken=1, branch_target=0x40 at phase_4, PC_W=8 -> pc=0x40, next fetch at 0x40. Separately, pc=0xFF with no branch -> pc=0x00.
- halt_req pulsed with phase_4, run kept at 1 -> wb_en still occurs, halted=1 and busy=0 next clk. Further phases/run produce no activity until rst_n.
- run dropped during EXEC -> instruction completes (wb_en, pc+1), then IDLE. run re-raised -> fetch at next phase_1 from the held pc.
